// File: rtl/sr_iter_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sr_iter_alu: iterative unsigned MUL / SQRT, DIV when SR_ITER_ALU_DIV_EN   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sr_iter_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] aux_o,
  output logic             err_o
);
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {M_MUL, M_SQRT, M_DIV, M_PASS} mode_e;

  state_e           state_q;
  mode_e            mode_q;
  logic [CW-1:0]    cnt_q, last_d;
  logic [WIDTH-1:0] hi_q, lo_q, opnd_q;
  logic [WIDTH-1:0] hi_d, lo_d, opnd_d, res_d, aux_d;
  logic             errp_q;
  logic             busy_q, done_q, err_q;
  logic [WIDTH-1:0] result_q, aux_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] sq_sh, sq_trial;
  logic             sq_ge;

  // hi:lo is the shared accumulator: product, sqrt remainder:radicand, div remainder:dividend
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign sq_sh    = {hi_q, lo_q[WIDTH-1 -: 2]};
  assign sq_trial = {opnd_q, 2'b01};
  assign sq_ge    = (sq_sh >= sq_trial);

`ifdef SR_ITER_ALU_DIV_EN
  logic [WIDTH:0] div_t;
  logic           div_ge;
  assign div_t  = {hi_q, lo_q[WIDTH-1]};
  assign div_ge = (div_t >= {1'b0, opnd_q});
`endif

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;
    res_d  = lo_q;
    aux_d  = hi_q;
    last_d = '0;
    case (mode_q)
      M_MUL: begin
        hi_d   = mul_sum[WIDTH:1];
        lo_d   = {mul_sum[0], lo_q[WIDTH-1:1]};
        last_d = CW'(WIDTH - 1);
        res_d  = lo_d;
        aux_d  = hi_d;
      end
      M_SQRT: begin
        hi_d   = sq_ge ? WIDTH'(sq_sh - sq_trial) : sq_sh[WIDTH-1:0];
        lo_d   = lo_q << 2;
        opnd_d = {opnd_q[WIDTH-2:0], sq_ge};
        last_d = CW'(HALF - 1);
        res_d  = opnd_d;
        aux_d  = hi_d;
      end
`ifdef SR_ITER_ALU_DIV_EN
      M_DIV: begin
        hi_d   = div_ge ? WIDTH'(div_t - {1'b0, opnd_q}) : div_t[WIDTH-1:0];
        lo_d   = {lo_q[WIDTH-2:0], div_ge};
        last_d = CW'(WIDTH - 1);
        res_d  = lo_d;
        aux_d  = hi_d;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= M_PASS;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      errp_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
      aux_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          hi_q   <= hi_d;
          lo_q   <= lo_d;
          opnd_q <= opnd_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == last_d) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_d;
            aux_q    <= aux_d;
            err_q    <= errp_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Accept from IDLE or DONE; degenerate ops preload their answer and take one pass step
      if (start_i && !busy_q) begin
        state_q <= S_RUN;
        busy_q  <= 1'b1;
        cnt_q   <= '0;
        hi_q    <= '0;
        errp_q  <= 1'b0;
        case (op_i)
          2'b00: begin
            mode_q <= M_MUL;
            lo_q   <= b_i;
            opnd_q <= a_i;
          end
          2'b01: begin
            mode_q <= M_SQRT;
            lo_q   <= a_i;
            opnd_q <= '0;
          end
`ifdef SR_ITER_ALU_DIV_EN
          2'b10: begin
            if (b_i == '0) begin
              mode_q <= M_PASS;
              lo_q   <= '1;
              hi_q   <= a_i;
              opnd_q <= '0;
              errp_q <= 1'b1;
            end else begin
              mode_q <= M_DIV;
              lo_q   <= a_i;
              opnd_q <= b_i;
            end
          end
`endif
          default: begin
            mode_q <= M_PASS;
            lo_q   <= '0;
            opnd_q <= '0;
            errp_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign aux_o    = aux_q;
  assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_iter_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sr_iter_alu: scoreboard bench for sr_iter_alu (WIDTH 32 and 8)         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sr_iter_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i, b_i;
  logic         busy_o, done_o, err_o;
  logic [W-1:0] result_o, aux_o;

  logic       s8;
  logic [1:0] op8;
  logic [7:0] a8, b8;
  logic       busy8, done8, err8;
  logic [7:0] res8, aux8;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] x;
    logic         e;
    int           acc;
    int           due;
  } exp_t;
  exp_t sbq[$];

  sr_iter_alu #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .aux_o(aux_o), .err_o(err_o)
  );

  sr_iter_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(s8), .op_i(op8), .a_i(a8), .b_i(b8),
    .busy_o(busy8), .done_o(done8), .result_o(res8), .aux_o(aux8), .err_o(err8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain arithmetic on 64-bit integers
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input int acc);
    exp_t e;
    longint unsigned la, lb, p, r;
    int n;
    la = longint'(a);
    lb = longint'(b);
    e.r = '0; e.x = '0; e.e = 1'b1; n = 1;
    case (op)
      2'b00: begin
        p = la * lb;
        e.r = p[31:0]; e.x = p[63:32]; e.e = 1'b0; n = W;
      end
      2'b01: begin
        r = longint'($floor($sqrt(real'(la))));
        while (r * r > la) r--;
        while ((r + 1) * (r + 1) <= la) r++;
        p = la - r * r;
        e.r = r[31:0]; e.x = p[31:0]; e.e = 1'b0; n = W / 2;
      end
`ifdef SR_ITER_ALU_DIV_EN
      2'b10: begin
        if (lb == 0) begin
          e.r = '1; e.x = a; e.e = 1'b1; n = 1;
        end else begin
          p = la / lb; r = la % lb;
          e.r = p[31:0]; e.x = r[31:0]; e.e = 1'b0; n = W;
        end
      end
`endif
      default: ;
    endcase
    e.acc = acc;
    e.due = acc + n;
    return e;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return W'($urandom_range(0, 300));
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done_o and watches busy_o in between
  always @(negedge clk) begin
    if (!rst) begin
      if (done_o) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_latency", 64'(cyc), 64'(e.due));
          chk("sb_result", result_o, e.r);
          chk("sb_aux", aux_o, e.x);
          chk("sb_err", err_o, e.e);
          chk("sb_busy_at_done", busy_o, 0);
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].due) begin
        chk("done_missing", 0, 1);
        void'(sbq.pop_front());
      end else if (sbq.size() > 0 && cyc >= sbq[0].acc) begin
        chk("busy_mid", busy_o, 1);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit pulse);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (busy_o) begin
      chk("issue_timeout", 1, 0);
      return;
    end
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    sbq.push_back(model(op, a, b, cyc + 1));
    @(negedge clk);
    start_i = 1'b0; op_i = 2'($urandom); a_i = W'($urandom); b_i = W'($urandom);
    if (pulse) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      if (busy_o) begin
        start_i = 1'b1; op_i = 2'b01;
        @(negedge clk);
        start_i = 1'b0;
      end
    end
  endtask

  task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] er, input logic [7:0] ex, input int n);
    int t0, k;
    @(negedge clk);
    s8 = 1'b1; op8 = op; a8 = a; b8 = b;
    t0 = cyc + 1;
    @(negedge clk);
    s8 = 1'b0;
    k = 0;
    while (!done8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("w8_done_seen", done8, 1);
    chk("w8_latency", 64'(cyc - t0), 64'(n));
    chk("w8_result", res8, er);
    chk("w8_aux", aux8, ex);
    chk("w8_err", err8, 0);
  endtask

  initial begin
    int guard;
    rst = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    s8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_aux", aux_o, 0);
    chk("rst_err", err_o, 0);

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b01, 32'd1000000, 32'd0, 1'b0);
    issue(2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(2'b01, 32'd0, 32'd0, 1'b0);
    issue(2'b00, 32'd7, 32'd6, 1'b1);
    issue(2'b01, 32'd81, 32'd0, 1'b0);
    issue(2'b11, 32'd5, 32'd9, 1'b0);
    issue(2'b10, 32'd100, 32'd7, 1'b0);
    issue(2'b10, 32'd100, 32'd0, 1'b0);

    // Abort a MUL ten edges after accept; the scoreboard entry is discarded
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (9) @(negedge clk);
    sbq.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    chk("abort_result", result_o, 0);
    chk("abort_aux", aux_o, 0);
    chk("abort_err", err_o, 0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(2'b00, 32'd3, 32'd5, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      issue(op, pick(), pick(), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (sbq.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", 64'(sbq.size()), 0);

    run8(2'b00, 8'hFF, 8'hFF, 8'h01, 8'hFE, 8);
    run8(2'b01, 8'hFF, 8'h00, 8'd15, 8'd30, 4);
    run8(2'b01, 8'd100, 8'h00, 8'd10, 8'd0, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
